// File: rtl/imem_dmem_arbiter_if.sv
// Fetch/data handshake of the core plus the unified memory bus, as seen by imem_dmem_arbiter.
// master is the arbiter's view; slave is the view of the core and memory around it.
interface imem_dmem_arbiter_if;
  logic [29:0] InstMem_Address;
  logic        InstMem_Read;
  logic [31:0] InstMem_In;
  logic        InstMem_Ready;

  logic [29:0] DataMem_Address;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [31:0] DataMem_Out;
  logic [31:0] DataMem_In;
  logic        DataMem_Ready;

  logic [29:0] Mem_Address;
  logic        Mem_Read;
  logic [3:0]  Mem_Write;
  logic [31:0] Mem_WriteData;
  logic [31:0] Mem_ReadData;
  logic        Mem_Ready;

  logic        Bus_Error;

  modport master (
    input  InstMem_Address, InstMem_Read,
    input  DataMem_Address, DataMem_Read, DataMem_Write, DataMem_Out,
    input  Mem_ReadData, Mem_Ready,
    output InstMem_In, InstMem_Ready,
    output DataMem_In, DataMem_Ready,
    output Mem_Address, Mem_Read, Mem_Write, Mem_WriteData,
    output Bus_Error
  );

  modport slave (
    output InstMem_Address, InstMem_Read,
    output DataMem_Address, DataMem_Read, DataMem_Write, DataMem_Out,
    output Mem_ReadData, Mem_Ready,
    input  InstMem_In, InstMem_Ready,
    input  DataMem_In, DataMem_Ready,
    input  Mem_Address, Mem_Read, Mem_Write, Mem_WriteData,
    input  Bus_Error
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported word memory between instruction fetch and data accesses.
// Define MEM_TIMEOUT_EN to build the Mem_Ready watchdog that drives Bus_Error.
module imem_dmem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clock,
  input  logic                reset,
  imem_dmem_arbiter_if.master bus
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [31:0]         ERR_DATA   = 32'hDEADBEEF;

  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("imem_dmem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [29:0]         addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [3:0]          wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic ireq, dreq;
  logic timeout, done;
  logic grant_i, grant_d;

  assign ireq = bus.InstMem_Read;
  assign dreq = bus.DataMem_Read | (bus.DataMem_Write != 4'b0000);
  assign done = (state_q != IDLE) && (bus.Mem_Ready || timeout);

`ifdef MEM_TIMEOUT_EN
  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;

  // Counts cycles spent in the current grant; fires in the TIMEOUT_CYCLES-th one.
  assign timeout = (state_q != IDLE) && !bus.Mem_Ready && (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = '0;
    if ((state_q != IDLE) && !done) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // A completing port still holds its request, so only the other port may take a direct handoff.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && !(ireq && (starve_q == STARVE_MAX))) grant_d = 1'b1;
        else if (ireq)                                   grant_i = 1'b1;
      end
      GNT_I:   grant_d = done && !timeout && dreq;
      GNT_D:   grant_i = done && !timeout && ireq;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;

    if (done) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 4'b0000;
    end

    if (grant_i) begin
      state_d  = GNT_I;
      addr_d   = bus.InstMem_Address;
      rd_d     = 1'b1;
      wr_d     = 4'b0000;
      starve_d = '0;
    end else if (grant_d) begin
      state_d = GNT_D;
      addr_d  = bus.DataMem_Address;
      wr_d    = bus.DataMem_Write;
      rd_d    = bus.DataMem_Read && (bus.DataMem_Write == 4'b0000);
      wdata_d = bus.DataMem_Out;
      if (ireq && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 4'b0000;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.Mem_Address   = addr_q;
  assign bus.Mem_Read      = rd_q;
  assign bus.Mem_Write     = wr_q;
  assign bus.Mem_WriteData = wdata_q;

  assign bus.InstMem_Ready = (state_q == GNT_I) && done;
  assign bus.DataMem_Ready = (state_q == GNT_D) && done;
  assign bus.InstMem_In    = (timeout && (state_q == GNT_I)) ? ERR_DATA : bus.Mem_ReadData;
  assign bus.DataMem_In    = (timeout && (state_q == GNT_D)) ? ERR_DATA : bus.Mem_ReadData;
  assign bus.Bus_Error     = timeout;

endmodule
